// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM states, default baud divisor and a
// counter-width helper.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;

  // 50 MHz / 115200 baud
  localparam int unsigned CLKS_PER_BIT_DEFAULT = 434;

  // Width needed to count 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_core_if.sv
// Upstream valid/ready byte stream feeding the UART transmitter.
interface uart_tx_core_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic             up_valid;
  logic             up_ready;
  logic [WIDTH-1:0] up_data;

  modport master (output up_valid, output up_data, input up_ready);
  modport slave  (input up_valid, input up_data, output up_ready);

endinterface

// File: rtl/uart_baud_tick.sv
// Baud divider: counts 0..CLKS_PER_BIT-1 while enabled and pulses tick on the
// last cycle of every serial bit.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic clk,
  input  logic arstn,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CntW = cnt_width(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + CntW'(1);
    end
  end

  assign tick = enable && (cnt_q == CntLast);

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter: accepts one word per valid/ready handshake and shifts it
// out as start bit, LSB-first data bits and STOP_BITS stop bits.
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic           clk,
  input  logic           arstn,
  uart_tx_core_if.slave  up,
  output logic           tx,
  output logic           busy
);

  // One counter walks data bits, then is reused to count stop bits.
  localparam int unsigned BitW = cnt_width((WIDTH > STOP_BITS) ? WIDTH : STOP_BITS);
  localparam logic [BitW-1:0] BitLast  = BitW'(WIDTH - 1);
  localparam logic [BitW-1:0] StopLast = BitW'(STOP_BITS - 1);

  uart_state_e      state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BitW-1:0]  bit_q, bit_d;
  logic             tx_q, tx_d;
  logic             tick;
  logic             handshake;

  assign up.up_ready = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign handshake   = up.up_valid & up.up_ready;
  assign tx          = tx_q;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk   (clk),
    .arstn (arstn),
    .clear (state_q == IDLE),
    .enable(state_q != IDLE),
    .tick  (tick)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (handshake) begin
          state_d = START;
          shift_d = up.up_data;
          bit_d   = '0;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_q == BitLast) begin
            state_d = STOP;
            bit_d   = '0;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + BitW'(1);
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (bit_q == StopLast) begin
            state_d = IDLE;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + BitW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: doc/uart_tx_core.md
UART_TX_CORE -- requirements
Module: uart_tx_core

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data bits per frame.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 434 (50 MHz / 115200): clk cycles per serial bit; legal range >= 2.
REQ-003 SHALL have parameter STOP_BITS, default 1: stop bits per frame; legal values 1 or 2.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port arstn, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port up_valid, input, 1 bit: upstream byte available.
REQ-007 SHALL have port up_ready, output, 1 bit: block can accept a byte this cycle.
REQ-008 SHALL have port up_data, input, WIDTH bits: byte to transmit.
REQ-009 SHALL have port tx, output, 1 bit: serial line, idle high.
REQ-010 SHALL have port busy, output, 1 bit: frame in progress.

Function
REQ-011 SHALL implement the FSM states IDLE, START, DATA and STOP.
REQ-012 SHALL drive up_ready = 1 only in IDLE and drive busy = ~up_ready, both decoded combinationally from state.
REQ-013 SHALL treat a handshake as up_valid & up_ready sampled at a rising edge; on that edge it SHALL latch up_data into a shift register, enter START, clear the baud counter and set tx to 0.
REQ-014 SHALL ignore up_data and up_valid outside a handshake; the transmitted byte SHALL equal the value sampled at the handshake edge.
REQ-015 SHALL hold tx = 0 in START for exactly CLKS_PER_BIT cycles, then enter DATA.
REQ-016 SHALL send WIDTH data bits LSB first in DATA, each held exactly CLKS_PER_BIT cycles, with a bit counter that terminates at WIDTH-1.
REQ-017 SHALL hold tx = 1 in STOP for exactly STOP_BITS*CLKS_PER_BIT cycles, then enter IDLE.
REQ-018 SHALL spend at least one cycle in IDLE between frames, so the minimum start-to-start period is (1+WIDTH+STOP_BITS)*CLKS_PER_BIT + 1 cycles.
REQ-019 SHALL use a baud counter of width $clog2(CLKS_PER_BIT) that counts 0..CLKS_PER_BIT-1 and wraps at each bit boundary with no drift.
REQ-020 SHALL drive tx directly from a flip-flop (glitch-free) and hold tx = 1 in IDLE.
REQ-021 SHALL keep up_ready = 1 in IDLE with up_valid low indefinitely, with no state change.

Reset
REQ-022 SHALL, while arstn = 0, immediately force tx = 1, state = IDLE, up_ready = 1, busy = 0, and clear the baud counter, bit counter and shift register.
REQ-023 SHALL abort any frame in progress when reset is asserted; the block SHALL never resume the aborted byte.
REQ-024 SHALL accept a new handshake on the first rising edge after arstn deasserts.

Structure
REQ-025 SHALL take the state enum typedef (IDLE/START/DATA/STOP) and the default CLKS_PER_BIT constant from the shared package uart_pkg.
REQ-026 SHALL implement the baud counter in a single sub-module, uart_baud_tick (inputs clear and enable; output tick on the last cycle of each bit); all other logic SHALL stay in uart_tx_core.

Verification (CLKS_PER_BIT=4, STOP_BITS=1, WIDTH=8 unless noted)
REQ-027 SHALL be verified with: reset asserted -> tx=1, up_ready=1, busy=0 while reset is low and on the first cycle after release.
REQ-028 SHALL be verified with: single byte 0xA5 -> tx levels 0,1,0,1,0,0,1,0,1,1, each held 4 cycles, starting at the handshake edge; up_ready=1 again at cycle 40.
REQ-029 SHALL be verified with: up_valid held high, bytes 0x00 then 0xFF -> second start bit falls exactly 41 cycles after the first; both bytes are decoded correctly.
REQ-030 SHALL be verified with: up_valid pulsed and up_data toggled every cycle during a frame -> no second handshake; the frame carries the byte sampled at the handshake.
REQ-031 SHALL be verified with: arstn pulsed low during data bit 3 -> tx=1 asynchronously; after release, byte 0x3C is transmitted intact.
REQ-032 SHALL be verified with: upstream valid/ready source supplying 0x11, 0x22, 0x33, 0x44, and STOP_BITS=2 -> four frames in order, each stop interval 8 cycles.
